ram_store_rmw: RTL and testbench
================================

Name: ram_store_rmw

Overview:
Store-side counterpart to the load data formatter. It accepts byte, halfword and word store requests from the memory stage and writes them into a word-wide data RAM that has no byte enables. Sub-word stores use a read-modify-write sequence. The block sits between the execute/memory pipeline register and the data RAM write port, and stalls the pipeline while a store is in flight.

Parameters:
WIDTH, 32, data and address width in bits; must be 32.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid_i  input  1  store request present this cycle
memtype_i  input  2  01 = byte, 10 = half, 00/11 = word
a_i  input  WIDTH  byte address of the store
wd_i  input  WIDTH  store data; the payload is taken from the low bits
req_ready_o  output  1  block can accept a request (high only in IDLE)
busy_o  output  1  store in flight; pipeline stall
done_o  output  1  one-cycle pulse in the cycle the RAM write is issued
ram_addr_o  output  WIDTH  word-aligned RAM address (bits [1:0] = 00)
ram_re_o  output  1  RAM read strobe
ram_rd_i  input  WIDTH  RAM read data, valid the cycle after ram_re_o
ram_we_o  output  1  RAM write strobe
ram_wd_o  output  WIDTH  RAM write data

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high.
- States: IDLE, READ, WRITE. All outputs are registered except ram_wd_o, which is combinational in WRITE.
- Reset values: state IDLE, req_ready_o=1, busy_o=0, done_o=0, ram_re_o=0, ram_we_o=0, ram_addr_o=0.
- IDLE:
  - If req_valid_i=1, capture memtype_i, a_i[1:0], wd_i, and set ram_addr_o = {a_i[WIDTH-1:2], 2'b00}.
  - Word store -> WRITE. Byte or half store -> READ.
  - If req_valid_i=0, stay in IDLE.
- READ: ram_re_o=1 for exactly one cycle, then -> WRITE.
- WRITE:
  - ram_we_o=1 and done_o=1 for exactly one cycle, then -> IDLE.
  - Word: ram_wd_o = captured wd.
  - Byte: ram_rd_i with lane a[1:0] replaced by wd[7:0]. Lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Half: a[1]=0 replaces bits [15:0]; a[1]=1 replaces bits [31:16]. The payload is wd[15:0].
- Latency from accept edge to write cycle: word 1 cycle, sub-word 2 cycles. Throughput: word one store per 2 cycles, sub-word one store per 3 cycles.
- Address alignment:
  - Half stores ignore a[0].
  - Word stores ignore a[1:0].
  - No misalignment trap is raised.
- memtype_i 00 and 11 are both treated as word.
- busy_o = (state != IDLE); req_ready_o = ~busy_o.
- req_valid_i while busy is ignored. The requester must hold the request until it sees ready.
- ram_addr_o is held stable from the accept edge through the WRITE cycle.
- Reset mid-operation: at the rst edge, state returns to IDLE and ram_re_o/ram_we_o drop. An uncommitted write is discarded with no partial write.
- ram_re_o and ram_we_o are never high in the same cycle.

Decomposition:
- Shared package (also used by the load formatter):
  - MEM_BYTE=2'b01, MEM_HALF=2'b10, MEM_WORD=2'b00.
  - State enum typedef (IDLE/READ/WRITE).
  - Byte-lane index type (logic [1:0]).
- One natural sub-module: store_merge.
  - Purely combinational.
  - Inputs: memtype, lane, old word, store data.
  - Output: merged word.
  - Unit-testable on its own; the FSM wrapper instantiates it.

Test Plan:
- RAM[0x100]=0xAABBCCDD; byte store wd=0x00000011 at a=0x102 -> re at cycle 1, we at cycle 2 with addr 0x100, wd=0xAA11CCDD, done_o pulse, busy_o high for cycles 1–2.
- Same RAM contents; half store wd=0x12345678 at a=0x102 -> write 0x5678CCDD. At a=0x101 -> write 0xAABB5678 (a[0] ignored).
- Word store wd=0xDEADBEEF at a=0x103 -> no read, we at cycle 1, addr 0x100, data 0xDEADBEEF. memtype_i=11 gives the identical response.
- Byte stores to lanes 0..3 (a=0x200..0x203, wd=0x01,0x02,0x03,0x04, RAM initially 0) issued back-to-back, holding valid until ready -> final RAM[0x200]=0x04030201, 3 cycles per store.
- Assert rst in the READ cycle of a byte store -> no ram_we_o ever issued, RAM unchanged. Next cycle the block is in IDLE with ready=1, and a new request is accepted normally.
- req_valid_i held high with changing data while busy -> only the originally accepted request is written. The second request is accepted only on the edge where ready=1.

Source files
------------

// File: rtl/ram_store_rmw_pkg.sv
// Shared memory-access definitions for the load formatter and the store RMW block.
// Access size codes, FSM state encoding and byte-lane index type.
package ram_store_rmw_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  typedef logic [1:0] lane_t;

  // 2'b11 is deliberately absent: it is treated as a word store.
  function automatic logic is_subword(input logic [1:0] mt);
    return (mt == MEM_BYTE) || (mt == MEM_HALF);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational merge of store data into an old RAM word.
// Zero latency, no flow control.
module store_merge
  import ram_store_rmw_pkg::*;
(
  input  logic [1:0]      i_memtype,
  input  lane_t           i_lane,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    case (i_memtype)
      MEM_BYTE: o_merged[{i_lane, 3'b000} +: 8] = i_wd[7:0];
      MEM_HALF: begin
        // Halfword lane is picked by a[1] only; a[0] is ignored.
        if (i_lane[1]) o_merged[31:16] = i_wd[15:0];
        else           o_merged[15:0]  = i_wd[15:0];
      end
      default:  o_merged = i_wd;
    endcase
  end

endmodule

// File: rtl/ram_store_rmw.sv
// Store path into a word RAM without byte enables; sub-word stores use read-modify-write.
// Write issued 1 cycle (word) or 2 cycles (sub-word) after accept; ready only in IDLE.
module ram_store_rmw
  import ram_store_rmw_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [1:0]       memtype_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             req_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ram_addr_o,
  output logic             ram_re_o,
  input  logic [WIDTH-1:0] ram_rd_i,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_wd_o
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_memtype;
  lane_t            r_lane;
  logic [WIDTH-1:0] r_wd;
  logic [WIDTH-1:0] r_addr;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_re;
  logic             r_we;
  logic             w_accept;
  logic [WIDTH-1:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && req_valid_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) w_next = is_subword(memtype_i) ? ST_READ : ST_WRITE;
      end
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_memtype <= MEM_WORD;
      r_lane    <= '0;
      r_wd      <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_WRITE);
      r_re    <= (w_next == ST_READ);
      r_we    <= (w_next == ST_WRITE);
      if (w_accept) begin
        r_memtype <= memtype_i;
        r_lane    <= a_i[1:0];
        r_wd      <= wd_i;
        r_addr    <= {a_i[WIDTH-1:2], 2'b00};
      end
    end
  end

  store_merge u_merge (
    .i_memtype (r_memtype),
    .i_lane    (r_lane),
    .i_old     (ram_rd_i),
    .i_wd      (r_wd),
    .o_merged  (w_merged)
  );

  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign ram_re_o    = r_re;
  assign ram_we_o    = r_we;
  assign ram_addr_o  = r_addr;
  assign ram_wd_o    = (r_state == ST_WRITE) ? w_merged : '0;

endmodule

// File: tb/tb_ram_store_rmw.sv
// Directed bench for ram_store_rmw with a behavioural word RAM on the write port.
// Vector table for single stores plus sequences for back-to-back, busy and reset cases.
module tb_ram_store_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [1:0]  memtype_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] wd_i = '0;
  logic        req_ready_o, busy_o, done_o, ram_re_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wd_o;
  logic [31:0] ram_rd_i = '0;

  logic [31:0] mem [0:1023];
  logic        ld = 1'b0;
  logic [9:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  int          we_cnt = 0;
  int          overlap = 0;
  int          cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  ram_store_rmw #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .memtype_i   (memtype_i),
    .a_i         (a_i),
    .wd_i        (wd_i),
    .req_ready_o (req_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_addr_o  (ram_addr_o),
    .ram_re_o    (ram_re_o),
    .ram_rd_i    (ram_rd_i),
    .ram_we_o    (ram_we_o),
    .ram_wd_o    (ram_wd_o)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) mem[ld_a] <= ld_d;
    if (ram_re_o) ram_rd_i <= mem[ram_addr_o[11:2]];
    if (ram_we_o) begin
      mem[ram_addr_o[11:2]] <= ram_wd_o;
      we_cnt <= we_cnt + 1;
    end
    if (ram_re_o && ram_we_o) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_a = addr[11:2];
    ld_d = data;
    ld   = 1'b1;
    @(negedge clk);
    ld   = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] init;
    logic [31:0] exp;
    bit          sub;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v);
    int  lat;
    bit  saw_re;
    logic [31:0] waddr;
    waddr = {v.a[31:2], 2'b00};
    preload(waddr, v.init);
    @(negedge clk);
    chk({v.name, ".ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    memtype_i   = v.mt;
    a_i         = v.a;
    wd_i        = v.wd;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk({v.name, ".busy"}, {31'd0, busy_o}, 32'd1);
    lat    = 1;
    saw_re = 1'b0;
    while (!ram_we_o && lat < 6) begin
      if (ram_re_o) saw_re = 1'b1;
      chk({v.name, ".addr_hold"}, ram_addr_o, waddr);
      @(negedge clk);
      lat++;
    end
    chk({v.name, ".latency"}, lat, v.sub ? 32'd2 : 32'd1);
    chk({v.name, ".read_issued"}, {31'd0, saw_re}, {31'd0, v.sub});
    chk({v.name, ".addr"}, ram_addr_o, waddr);
    chk({v.name, ".wdata"}, ram_wd_o, v.exp);
    chk({v.name, ".done"}, {31'd0, done_o}, 32'd1);
    @(negedge clk);
    chk({v.name, ".idle"}, {29'd0, busy_o, done_o, ram_we_o}, 32'd0);
    chk({v.name, ".ram"}, mem[waddr[11:2]], v.exp);
  endtask

  initial begin
    int t0;
    int cyc_acc [4];
    int we_before;

    vecs[0] = '{"byte_l2",   2'b01, 32'h102, 32'h00000011, 32'hAABBCCDD, 32'hAA11CCDD, 1'b1};
    vecs[1] = '{"half_hi",   2'b10, 32'h102, 32'h12345678, 32'hAABBCCDD, 32'h5678CCDD, 1'b1};
    vecs[2] = '{"half_a0",   2'b10, 32'h101, 32'h12345678, 32'hAABBCCDD, 32'hAABB5678, 1'b1};
    vecs[3] = '{"word_00",   2'b00, 32'h103, 32'hDEADBEEF, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{"word_11",   2'b11, 32'h103, 32'hDEADBEEF, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{"byte_l0",   2'b01, 32'h100, 32'hFFFFFF5A, 32'hAABBCCDD, 32'hAABBCC5A, 1'b1};
    vecs[6] = '{"byte_l3",   2'b01, 32'h103, 32'h00000077, 32'hAABBCCDD, 32'h77BBCCDD, 1'b1};
    vecs[7] = '{"half_lo",   2'b10, 32'h100, 32'h0000ABCD, 32'hAABBCCDD, 32'hAABBABCD, 1'b1};
    vecs[8] = '{"half_a3",   2'b10, 32'h103, 32'h9999BEEF, 32'hAABBCCDD, 32'hBEEFCCDD, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst.busy_done", {30'd0, busy_o, done_o}, 32'd0);
    chk("rst.strobes", {30'd0, ram_re_o, ram_we_o}, 32'd0);
    chk("rst.addr", ram_addr_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back byte stores, valid held until ready.
    preload(32'h200, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      t0 = 0;
      while (!req_ready_o && t0 < 8) begin
        @(negedge clk);
        t0++;
      end
      chk("b2b.ready_wait", {31'd0, req_ready_o}, 32'd1);
      cyc_acc[i]  = cyc;
      req_valid_i = 1'b1;
      memtype_i   = 2'b01;
      a_i         = 32'h200 + i;
      wd_i        = i + 1;
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b.spacing", cyc_acc[i] - cyc_acc[i-1], 32'd3);
    repeat (3) @(negedge clk);
    chk("b2b.ram", mem[32'h200 >> 2], 32'h04030201);

    // Request held and changed while busy: only the accepted one is written.
    preload(32'h100, 32'hAABBCCDD);
    @(negedge clk);
    req_valid_i = 1'b1; memtype_i = 2'b01; a_i = 32'h100; wd_i = 32'h55;
    @(negedge clk);
    memtype_i = 2'b00; a_i = 32'h300; wd_i = 32'h11111111;
    chk("busy.addr_held", ram_addr_o, 32'h100);
    chk("busy.read", {31'd0, ram_re_o}, 32'd1);
    @(negedge clk);
    wd_i = 32'h22222222;
    chk("busy.we", {31'd0, ram_we_o}, 32'd1);
    chk("busy.wdata", ram_wd_o, 32'hAABBCC55);
    chk("busy.addr", ram_addr_o, 32'h100);
    @(negedge clk);
    chk("busy.ready_again", {30'd0, req_ready_o, ram_we_o}, 32'd2);
    wd_i = 32'h33333333;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("busy.second_we", {30'd0, ram_we_o, ram_re_o}, 32'd2);
    chk("busy.second_addr", ram_addr_o, 32'h300);
    chk("busy.second_data", ram_wd_o, 32'h33333333);
    @(negedge clk);
    chk("busy.ram_first", mem[32'h100 >> 2], 32'hAABBCC55);
    chk("busy.ram_second", mem[32'h300 >> 2], 32'h33333333);

    // Reset during the READ cycle discards the write.
    preload(32'h100, 32'hAABBCCDD);
    @(negedge clk);
    we_before   = we_cnt;
    req_valid_i = 1'b1; memtype_i = 2'b01; a_i = 32'h102; wd_i = 32'h99;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rstmid.read", {31'd0, ram_re_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rstmid.quiet", {29'd0, busy_o, ram_re_o, ram_we_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid.no_write", we_cnt - we_before, 32'd0);
    chk("rstmid.ram", mem[32'h100 >> 2], 32'hAABBCCDD);
    run_vec(vecs[0]);

    chk("no_re_we_overlap", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
